mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped timer/counter peripheral that answers CPU data-memory-stage accesses.
- Sits beside the data memory on the same bus: addr, rd, wr, wdata, rdata.
- The CPU is the initiator; this block is a responder.
- Provides a prescaled 32-bit up-counter, a compare match with optional auto-reload, an overflow flag and a level interrupt.

Parameters:
- BASE, 7'h70: word address of register 0. Must be 8-word aligned (BASE[2:0] == 0).
- ID, 32'h544D5231: constant returned by the ID register.

Ports:
- clk  input  1: clock. All state updates on the rising edge.
- rst_n  input  1: synchronous, active-low reset.
- addr  input  7: word address, equal to the CPU ALU result [8:2].
- rd  input  1: read strobe.
- wr  input  1: write strobe.
- wdata  input  32: write data.
- rdata  output  32: read data. Combinational, same cycle as addr/rd.
- hit  output  1: addr decodes to this block (addr[6:3] == BASE[6:3]). Used by the bus mux to select rdata.
- irq  output  1: interrupt, level, active-high.

Behaviour:
- Decode: sel = hit. Register offset = addr[2:0]. Writes take effect only when sel & wr, at the clock edge.
- Register map (offset: name, access):
  - 0 CTRL, RW: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, bits[15:8] PRESCALE. Other bits read 0.
  - 1 COUNT, RW.
  - 2 COMPARE, RW.
  - 3 STATUS, read / write-1-to-clear: bit0 MATCH, bit1 OVF.
  - 4 ID, RO.
  - 5-7: read 0; writes ignored.
- rdata = register value when sel & rd, else 32'h0. Reads have no side effects.
- Reset (rst_n low at an edge): CTRL=0, COUNT=0, COMPARE=32'hFFFFFFFF, STATUS=0, prescaler pcnt=0. After reset: irq=0, rdata=0.
- Prescaler: 8-bit pcnt advances only while EN=1.
  - When pcnt == PRESCALE, pcnt<=0 and a tick is generated that cycle. Otherwise pcnt<=pcnt+1.
  - PRESCALE=0 gives a tick every cycle. PRESCALE=N gives a tick every N+1 cycles.
  - EN=0 freezes pcnt and COUNT. pcnt is not cleared.
- On tick:
  - If COUNT == COMPARE: MATCH<=1. COUNT<=0 if AUTORELOAD, else COUNT<=COUNT+1 (mod 2^32).
  - Else COUNT<=COUNT+1.
  - If COUNT == 32'hFFFFFFFF: OVF<=1 and COUNT wraps to 0. If this is also a match with AUTORELOAD, COUNT is 0 either way.
- Writing CTRL also clears pcnt to 0, so a prescale change starts a full period.
- Simultaneous events:
  - CPU write to COUNT and a tick in the same cycle: the write wins, no increment that cycle. MATCH/OVF are still evaluated against the old COUNT.
  - STATUS write-1-to-clear on the same cycle a flag sets: the set wins (flag stays 1).
  - Writing 0 bits to STATUS leaves those flags unchanged.
  - Write to COMPARE and a tick in the same cycle: the match uses the old COMPARE.
- irq = IRQEN & (MATCH | OVF). Combinational from registers, so it deasserts the cycle after the clearing write.
- Reset mid-count: all state returns to reset values at that edge regardless of rd/wr.
- rd and wr both high: the write is performed and rdata shows the pre-write value.

Test Plan:
- Reset, then read offsets 0-4 with addr=7'h70..7'h74 -> rdata 0, 0, FFFFFFFF, 0, 544D5231. Read addr=7'h10 -> hit=0, rdata=0.
- Write COMPARE=3, CTRL=32'h0000_0007 (EN, AUTORELOAD, IRQEN, PRESCALE=0):
  - COUNT reads 1, 2, 3 on successive cycles.
  - On the cycle after COUNT=3: MATCH=1, irq=1, COUNT=0.
  - Write STATUS=1 -> MATCH=0, irq=0 next cycle.
- CTRL=32'h0000_0401 (EN, PRESCALE=4) -> COUNT increments once every 5 cycles.
  - Write EN=0 mid-period -> COUNT and pcnt hold.
  - Re-enable -> counting resumes with pcnt=0.
- Write COUNT=32'hFFFFFFFE, CTRL=1, COMPARE=5 -> after two ticks COUNT=0, OVF=1, MATCH=0, irq=0 (IRQEN=0).
- Simultaneous events:
  - COUNT write of 32'h100 on a tick cycle -> COUNT=32'h100 next cycle, not 32'h101.
  - STATUS clear on the same cycle MATCH sets -> MATCH reads 1.
- Assert rst_n=0 for one edge with COUNT=9, MATCH=1, EN=1 -> all registers at reset values, irq=0, and COUNT stays 0 after rst_n releases (EN=0).

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer/counter that responds to CPU data-memory-stage accesses.
//
// The block provides a prescaled 32-bit up-counter, a compare match with optional
// auto-reload, an overflow flag and a level interrupt.
//
// Ports:
//   clk    - clock; all state changes on its rising edge
//   rst_n  - synchronous, active-low reset
//   addr   - word address (CPU ALU result [8:2])
//   rd     - read strobe
//   wr     - write strobe
//   wdata  - write data
//   rdata  - combinational read data; zero unless this block is selected and rd is high
//   hit    - addr falls inside this block's 8-word window
//   irq    - level interrupt: IRQEN & (MATCH | OVF)
//
// Register map (word offsets from BASE):
//   0 CTRL    RW   bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, bits[15:8] PRESCALE
//   1 COUNT   RW
//   2 COMPARE RW
//   3 STATUS  W1C  bit0 MATCH, bit1 OVF
//   4 ID      RO
//   5-7       read 0, writes ignored
module mmio_timer #(
    parameter logic [6:0]  BASE = 7'h70,
    parameter logic [31:0] ID   = 32'h544D5231
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_ID      = 3'd4;

    logic        en_reg, autoreload_reg, irqen_reg;
    logic [7:0]  prescale_reg;
    logic [7:0]  pcnt_reg, pcnt_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg;
    logic        match_reg, match_next;
    logic        ovf_reg, ovf_next;

    logic        wr_ctrl, wr_count, wr_compare, wr_status;
    logic        tick, is_match, is_wrap;

    assign hit        = (addr[6:3] == BASE[6:3]);
    assign wr_ctrl    = hit && wr && (addr[2:0] == OFF_CTRL);
    assign wr_count   = hit && wr && (addr[2:0] == OFF_COUNT);
    assign wr_compare = hit && wr && (addr[2:0] == OFF_COMPARE);
    assign wr_status  = hit && wr && (addr[2:0] == OFF_STATUS);

    // Compare and wrap are judged against the values held before this edge, so a
    // concurrent write to COUNT or COMPARE never changes the outcome of this tick.
    assign tick     = en_reg && (pcnt_reg == prescale_reg);
    assign is_match = (count_reg == compare_reg);
    assign is_wrap  = (count_reg == 32'hFFFF_FFFF);

    always_comb begin
        pcnt_next = pcnt_reg;
        if (wr_ctrl) begin
            // A CTRL write restarts the prescale period from zero.
            pcnt_next = 8'd0;
        end else if (en_reg) begin
            pcnt_next = tick ? 8'd0 : pcnt_reg + 8'd1;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (wr_count) begin
            count_next = wdata;
        end else if (tick) begin
            // Natural 32-bit wrap covers the overflow case.
            count_next = (is_match && autoreload_reg) ? 32'd0 : count_reg + 32'd1;
        end
    end

    // Setting a flag takes priority over a same-cycle write-1-to-clear.
    always_comb begin
        match_next = (match_reg && !(wr_status && wdata[0])) || (tick && is_match);
        ovf_next   = (ovf_reg   && !(wr_status && wdata[1])) || (tick && is_wrap);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_reg         <= 1'b0;
            autoreload_reg <= 1'b0;
            irqen_reg      <= 1'b0;
            prescale_reg   <= 8'd0;
            pcnt_reg       <= 8'd0;
            count_reg      <= 32'd0;
            compare_reg    <= 32'hFFFF_FFFF;
            match_reg      <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_reg         <= wdata[0];
                autoreload_reg <= wdata[1];
                irqen_reg      <= wdata[2];
                prescale_reg   <= wdata[15:8];
            end
            if (wr_compare) begin
                compare_reg <= wdata;
            end
            pcnt_reg  <= pcnt_next;
            count_reg <= count_next;
            match_reg <= match_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Reads are side-effect free; with rd and wr together the pre-write value shows.
    always_comb begin
        rdata = 32'd0;
        if (hit && rd) begin
            case (addr[2:0])
                OFF_CTRL:    rdata = {16'd0, prescale_reg, 5'd0, irqen_reg, autoreload_reg, en_reg};
                OFF_COUNT:   rdata = count_reg;
                OFF_COMPARE: rdata = compare_reg;
                OFF_STATUS:  rdata = {30'd0, ovf_reg, match_reg};
                OFF_ID:      rdata = ID;
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign irq = irqen_reg && (match_reg || ovf_reg);

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: drives mmio_timer with directed scenarios and randomized bus
// traffic, checking rdata, hit and irq every cycle against a register-level model.
module tb_mmio_timer;

    localparam logic [6:0]  BASE = 7'h70;
    localparam logic [31:0] ID   = 32'h544D5231;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  addr = 7'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model: registers as the CPU sees them.
    logic [31:0] m_ctrl;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_match, m_ovf;
    int          m_pcnt;
    logic [31:0] last_rdata;

    mmio_timer #(.BASE(BASE), .ID(ID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata),
        .hit   (hit),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] a, input logic r);
        logic [31:0] v;
        v = 32'd0;
        if (r && (a >= BASE) && (a < BASE + 7'd8)) begin
            case (int'(a - BASE))
                0: v = m_ctrl;
                1: v = m_count;
                2: v = m_compare;
                3: v = {30'd0, m_ovf, m_match};
                4: v = ID;
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        m_ctrl = 32'd0;
        m_count = 32'd0;
        m_compare = 32'hFFFF_FFFF;
        m_match = 1'b0;
        m_ovf = 1'b0;
        m_pcnt = 0;
    endtask

    // One clock edge of the peripheral, written from the register-level rules.
    task automatic model_edge(input logic rn, input logic [6:0] a, input logic w, input logic [31:0] d);
        bit          en, ticked, set_m, set_o;
        int          prescale;
        longint      nxt;
        logic [31:0] cnt_new;
        int          off;
        if (!rn) begin
            model_reset();
            return;
        end
        en = m_ctrl[0];
        prescale = int'(m_ctrl[15:8]);
        ticked = en && (m_pcnt == prescale);
        set_m = ticked && (m_count == m_compare);
        set_o = ticked && (m_count == 32'hFFFF_FFFF);
        cnt_new = m_count;
        if (ticked) begin
            nxt = (longint'(m_count) + 1) % 64'h1_0000_0000;
            if (set_m && m_ctrl[1]) nxt = 0;
            cnt_new = nxt[31:0];
        end
        if (en) m_pcnt = ticked ? 0 : m_pcnt + 1;
        off = -1;
        if (w && (a >= BASE) && (a < BASE + 7'd8)) off = int'(a - BASE);
        if (off == 3) begin
            if (d[0]) m_match = 1'b0;
            if (d[1]) m_ovf = 1'b0;
        end
        if (set_m) m_match = 1'b1;
        if (set_o) m_ovf = 1'b1;
        m_count = cnt_new;
        case (off)
            0: begin m_ctrl = d & 32'h0000_FF07; m_pcnt = 0; end
            1: m_count = d;
            2: m_compare = d;
            default: ;
        endcase
    endtask

    // One bus cycle: drive, sample mid-cycle against the model, then clock both.
    task automatic bus_cycle(input logic rn, input logic [6:0] a, input logic r, input logic w,
                             input logic [31:0] d);
        rst_n = rn; addr = a; rd = r; wr = w; wdata = d;
        @(negedge clk);
        last_rdata = rdata;
        check_value("rdata", rdata, model_read(a, r));
        check_value("hit", {31'd0, hit}, {31'd0, (a[6:3] == BASE[6:3])});
        check_value("irq", {31'd0, irq}, {31'd0, m_ctrl[2] & (m_match | m_ovf)});
        @(posedge clk);
        model_edge(rn, a, w, d);
        #1;
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d);
        bus_cycle(1'b1, BASE + 7'(off), 1'b0, 1'b1, d);
    endtask

    task automatic rd_expect(input string tag, input int off, input logic [31:0] exp);
        bus_cycle(1'b1, BASE + 7'(off), 1'b1, 1'b0, 32'd0);
        check_value(tag, last_rdata, exp);
    endtask

    task automatic rd_reg(input int off);
        bus_cycle(1'b1, BASE + 7'(off), 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        logic [6:0]  ra;
        logic [31:0] rw;
        model_reset();
        // Reset and reset-value reads.
        bus_cycle(1'b0, 7'h00, 1'b0, 1'b0, 32'd0);
        bus_cycle(1'b0, 7'h00, 1'b0, 1'b0, 32'd0);
        check_value("rst_irq", {31'd0, irq}, 32'd0);
        rd_expect("rst_ctrl", 0, 32'd0);
        rd_expect("rst_count", 1, 32'd0);
        rd_expect("rst_compare", 2, 32'hFFFF_FFFF);
        rd_expect("rst_status", 3, 32'd0);
        rd_expect("rst_id", 4, ID);
        bus_cycle(1'b1, 7'h10, 1'b1, 1'b0, 32'd0);
        check_value("miss_rdata", last_rdata, 32'd0);
        check_value("miss_hit", {31'd0, hit}, 32'd0);

        // Compare match with auto-reload and interrupt.
        wr_reg(2, 32'd3);
        wr_reg(0, 32'h0000_0007);
        rd_expect("cnt0", 1, 32'd0);
        rd_expect("cnt1", 1, 32'd1);
        rd_expect("cnt2", 1, 32'd2);
        rd_expect("cnt3", 1, 32'd3);
        rd_expect("match_set", 3, 32'd1);
        check_value("match_irq", {31'd0, irq}, 32'd1);
        wr_reg(3, 32'd1);
        rd_expect("match_clr", 3, 32'd0);
        check_value("clr_irq", {31'd0, irq}, 32'd0);

        // Prescale 4, pause and resume.
        wr_reg(0, 32'd0);
        wr_reg(3, 32'd3);
        wr_reg(1, 32'd0);
        wr_reg(0, 32'h0000_0401);
        for (int i = 0; i < 12; i++) rd_reg(1);
        check_value("presc_cnt", last_rdata, 32'd2);
        wr_reg(0, 32'h0000_0400);
        for (int i = 0; i < 7; i++) rd_reg(1);
        wr_reg(0, 32'h0000_0401);
        for (int i = 0; i < 12; i++) rd_reg(1);

        // Overflow without interrupt enable.
        wr_reg(0, 32'd0);
        wr_reg(3, 32'd3);
        wr_reg(2, 32'd5);
        wr_reg(1, 32'hFFFF_FFFE);
        wr_reg(0, 32'd1);
        rd_expect("ovf_c0", 1, 32'hFFFF_FFFE);
        rd_expect("ovf_c1", 1, 32'hFFFF_FFFF);
        rd_expect("ovf_status", 3, 32'd2);
        check_value("ovf_irq", {31'd0, irq}, 32'd0);

        // COUNT write colliding with a tick.
        wr_reg(1, 32'h100);
        rd_expect("wr_wins", 1, 32'h100);

        // STATUS clear colliding with MATCH set.
        wr_reg(3, 32'd3);
        wr_reg(2, 32'd12);
        wr_reg(1, 32'd10);
        rd_reg(1);
        rd_reg(1);
        wr_reg(3, 32'd1);
        rd_expect("set_wins", 3, 32'd1);

        // Reset mid-count.
        wr_reg(0, 32'h0000_0005);
        wr_reg(1, 32'd9);
        bus_cycle(1'b0, BASE + 7'd1, 1'b1, 1'b1, 32'h1234);
        check_value("rst2_irq", {31'd0, irq}, 32'd0);
        rd_expect("rst2_ctrl", 0, 32'd0);
        rd_expect("rst2_compare", 2, 32'hFFFF_FFFF);
        rd_expect("rst2_status", 3, 32'd0);
        rd_expect("rst2_cnt_a", 1, 32'd0);
        rd_expect("rst2_cnt_b", 1, 32'd0);

        // Randomized traffic, checked against the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 85) ra = BASE + 7'($urandom_range(0, 7));
            else ra = 7'($urandom);
            case ($urandom_range(0, 3))
                0: rw = $urandom;
                1: rw = {16'd0, 8'($urandom_range(0, 3)), 5'd0, 3'($urandom)};
                2: rw = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
                default: rw = 32'($urandom_range(0, 12));
            endcase
            bus_cycle(($urandom_range(0, 199) != 0), ra, 1'($urandom), ($urandom_range(0, 99) < 30), rw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
